pe_mac_param: RTL and testbench
===============================

PE_MAC_PARAM -- requirements
Module: pe_mac_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which sets the signed two's-complement operand, weight and psum width.
REQ-002 SHALL have parameter FRAC_W, default 8, which sets the fractional bits, so the default format is Q8.8; legal range is 1..DATA_W-1.
REQ-003 SHALL have parameter WDEPTH, default 2, which sets the shadow-weight FIFO depth; legal range is 1..8.
REQ-004 SHALL have parameter SAT_EN, default 1, where 1 saturates psum on overflow and 0 wraps it.
REQ-005 SHALL have parameter ROUND_EN, default 1, where 1 rounds half-up before the product shift and 0 truncates.
REQ-006 SHALL have the following ports, clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  reset, asynchronous, active-low
  pe_enabled  in  1  PE enable
  pe_valid_in  in  1  input sample valid (from west)
  pe_input_in  in  DATA_W  activation (from west)
  pe_psum_in  in  DATA_W  partial sum (from north)
  pe_accept_w_in  in  1  weight load strobe (from north)
  pe_weight_in  in  DATA_W  weight (from north)
  pe_switch_in  in  1  promote next shadow weight to active
  pe_valid_out  out  1  registered valid (east/south)
  pe_input_out  out  DATA_W  registered activation (east)
  pe_psum_out  out  DATA_W  registered MAC result (south)
  pe_accept_w_out  out  1  registered load strobe (south)
  pe_weight_out  out  DATA_W  registered weight forward (south)
  pe_switch_out  out  1  registered switch (east)
  pe_ovf_out  out  1  psum saturated or wrapped this result
  pe_wdrop_out  out  1  sticky: a weight was dropped because the FIFO was full
  pe_wcount_out  out  clog2(WDEPTH+1)  shadow FIFO occupancy

Function
REQ-007 SHALL freeze all state while pe_enabled=0, except that pe_valid_out, pe_accept_w_out and pe_switch_out are cleared to 0.
REQ-008 SHALL, with pe_enabled=1, register every output exactly one cycle after its input; there is no combinational in-to-out path.
REQ-009 SHALL, when pe_accept_w_in=1, register pe_weight_out<=pe_weight_in and pe_accept_w_out<=1; otherwise pe_weight_out<=0 and pe_accept_w_out<=0.
REQ-010 SHALL push pe_weight_in into the shadow FIFO on pe_accept_w_in=1 when the FIFO is not full; when full, it SHALL drop the weight and set pe_wdrop_out.
REQ-011 SHALL, on pe_switch_in=1 with the FIFO non-empty, pop the FIFO head into the active weight; with the FIFO empty, the active weight holds.
REQ-012 SHALL treat a simultaneous push and pop as follows: the pop sees the pre-edge head, the push is accepted even when the FIFO is full (count unchanged), and no drop occurs.
REQ-013 SHALL register pe_switch_out<=pe_switch_in every enabled cycle.
REQ-014 SHALL, on pe_valid_in=1, compute the product as a 2*DATA_W-bit signed value pe_input_in*active, where active is the pre-edge value, even if a switch occurs in the same cycle.
REQ-015 SHALL scale the product as follows: if ROUND_EN, add 2^(FRAC_W-1) and then arithmetic-shift right by FRAC_W; otherwise arithmetic-shift only.
REQ-016 SHALL form the sum in DATA_W+1 bits as scaled product plus pe_psum_in.
REQ-017 SHALL check the range of both the scaled product and the sum against the DATA_W range.
REQ-018 SHALL, on overflow, set pe_ovf_out=1 and, if SAT_EN, clamp to the max value 0x7FFF or the min value 0x8000; otherwise it SHALL keep the low DATA_W bits.
REQ-019 SHALL, on pe_valid_in=1, register pe_psum_out<=result, pe_input_out<=pe_input_in and pe_valid_out<=1.
REQ-020 SHALL, on pe_valid_in=0, register pe_psum_out<=0, pe_input_out<=0, pe_valid_out<=0 and pe_ovf_out<=0.
REQ-021 SHALL clear pe_wdrop_out only by reset.

Reset
REQ-022 SHALL, while rst=0, immediately force to 0 all outputs, the active weight, all FIFO entries and pointers, and pe_wcount_out, regardless of clk.
REQ-023 SHALL discard any MAC or FIFO operation in flight when reset asserts mid-stream.
REQ-024 SHALL not change state on the first rising edge after rst deasserts unless the inputs request it.

Verification
REQ-025 SHALL cover load and switch: load 4.34765625 (0x0459), switch, then valid with input 2.0 (0x0200) and psum 0; pe_psum_out must be 0x08B2 (8.6953125) one cycle later.
REQ-026 SHALL cover switch timing: active=4.34765625, FIFO head=10.6015625, switch and valid in the same cycle with input 2.0; the result must use 4.34765625, and a MAC on the next cycle must use 10.6015625.
REQ-027 SHALL cover saturation: input 127.0 (0x7F00), weight 2.0, psum 0; with SAT_EN=1, pe_psum_out=0x7FFF and pe_ovf_out=1; with SAT_EN=0, the low 16 bits and pe_ovf_out=1.
REQ-028 SHALL cover rounding: input 0x0001, weight 0x0080, psum 0; with ROUND_EN=1 the result is 0x0001, and with ROUND_EN=0 it is 0x0000.
REQ-029 SHALL cover FIFO overflow: with WDEPTH=2, three loads without a switch give pe_wcount_out=2 and pe_wdrop_out=1; two switches then yield the first and second weights in order.
REQ-030 SHALL cover reset mid-stream: assert rst=0 between clock edges during a valid burst; all outputs must go to 0 at once, and after release a MAC with active weight 0 must give pe_psum_out=pe_psum_in.

Source files
------------

// File: rtl/pe_mac_param.sv
// Systolic PE: fixed-point MAC with double-buffered (shadow FIFO) weights; every output registered, 1-cycle latency.
// No backpressure: data moves every enabled cycle, and a weight load into a full shadow FIFO is dropped and flagged.

module fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop_ok);
  assign drop     = push && !push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

module pe_mac_param #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int WDEPTH   = 2,
  parameter int SAT_EN   = 1,
  parameter int ROUND_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pe_enabled,
  input  logic                         pe_valid_in,
  input  logic [DATA_W-1:0]            pe_input_in,
  input  logic [DATA_W-1:0]            pe_psum_in,
  input  logic                         pe_accept_w_in,
  input  logic [DATA_W-1:0]            pe_weight_in,
  input  logic                         pe_switch_in,
  output logic                         pe_valid_out,
  output logic [DATA_W-1:0]            pe_input_out,
  output logic [DATA_W-1:0]            pe_psum_out,
  output logic                         pe_accept_w_out,
  output logic [DATA_W-1:0]            pe_weight_out,
  output logic                         pe_switch_out,
  output logic                         pe_ovf_out,
  output logic                         pe_wdrop_out,
  output logic [$clog2(WDEPTH+1)-1:0]  pe_wcount_out
);
  localparam int PW2 = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]        active_w;
  logic [DATA_W-1:0]        head_w;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_drop;

  logic signed [PW2-1:0]    in_ext;
  logic signed [PW2-1:0]    w_ext;
  logic signed [PW2-1:0]    prod;
  logic signed [PW2-1:0]    rnd_c;
  logic signed [PW2-1:0]    max_c;
  logic signed [PW2-1:0]    min_c;
  logic signed [PW2-1:0]    prod_sh;
  logic                     prod_ovf;
  logic [DATA_W-1:0]        prod_fit;
  logic [DATA_W:0]          sum;
  logic                     sum_ovf;
  logic [DATA_W-1:0]        result;
  logic                     ovf;

  fifo #(
    .WIDTH (DATA_W),
    .DEPTH (WDEPTH)
  ) u_wfifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pe_enabled && pe_accept_w_in),
    .push_dat (pe_weight_in),
    .pop      (pe_enabled && pe_switch_in),
    .head_dat (head_w),
    .count    (pe_wcount_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  always_comb begin
    in_ext  = {{DATA_W{pe_input_in[DATA_W-1]}}, pe_input_in};
    w_ext   = {{DATA_W{active_w[DATA_W-1]}}, active_w};
    prod    = in_ext * w_ext;
    rnd_c   = '0;
    if (ROUND_EN != 0) rnd_c[FRAC_W-1] = 1'b1;
    max_c   = '0;
    max_c[DATA_W-2:0] = '1;
    min_c   = '1;
    min_c[DATA_W-2:0] = '0;
    prod_sh  = (prod + rnd_c) >>> FRAC_W;
    prod_ovf = (prod_sh > max_c) || (prod_sh < min_c);

    // Product is brought into DATA_W range before the add so the sum needs only one guard bit.
    prod_fit = prod_sh[DATA_W-1:0];
    if (prod_ovf && (SAT_EN != 0)) prod_fit = prod_sh[PW2-1] ? MIN_V : MAX_V;

    sum     = {prod_fit[DATA_W-1], prod_fit} + {pe_psum_in[DATA_W-1], pe_psum_in};
    sum_ovf = (sum[DATA_W] != sum[DATA_W-1]);
    result  = sum[DATA_W-1:0];
    if (sum_ovf && (SAT_EN != 0)) result = sum[DATA_W] ? MIN_V : MAX_V;
    ovf = prod_ovf || sum_ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_w        <= '0;
      pe_valid_out    <= 1'b0;
      pe_input_out    <= '0;
      pe_psum_out     <= '0;
      pe_accept_w_out <= 1'b0;
      pe_weight_out   <= '0;
      pe_switch_out   <= 1'b0;
      pe_ovf_out      <= 1'b0;
      pe_wdrop_out    <= 1'b0;
    end else if (!pe_enabled) begin
      pe_valid_out    <= 1'b0;
      pe_accept_w_out <= 1'b0;
      pe_switch_out   <= 1'b0;
    end else begin
      pe_accept_w_out <= pe_accept_w_in;
      pe_weight_out   <= pe_accept_w_in ? pe_weight_in : '0;
      pe_switch_out   <= pe_switch_in;
      if (pe_switch_in && !fifo_empty) active_w <= head_w;
      if (fifo_drop) pe_wdrop_out <= 1'b1;
      if (pe_valid_in) begin
        pe_valid_out <= 1'b1;
        pe_input_out <= pe_input_in;
        pe_psum_out  <= result;
        pe_ovf_out   <= ovf;
      end else begin
        pe_valid_out <= 1'b0;
        pe_input_out <= '0;
        pe_psum_out  <= '0;
        pe_ovf_out   <= 1'b0;
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_pe_mac_param.sv
// Directed bench for pe_mac_param: default instance plus a wrap/truncate instance sharing the same stimulus.
module tb_pe_mac_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, vin, accw, sw;
  logic [15:0] din, pin, win;

  logic        vout, aout, swout, ovf, wdrop;
  logic [15:0] dout, pout, wout;
  logic [1:0]  wcnt;
  logic        a_vout, a_aout, a_swout, a_ovf, a_wdrop;
  logic [15:0] a_dout, a_pout, a_wout;
  logic [1:0]  a_wcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_mac_param dut (
    .clk(clk), .rst(rst), .pe_enabled(en), .pe_valid_in(vin), .pe_input_in(din),
    .pe_psum_in(pin), .pe_accept_w_in(accw), .pe_weight_in(win), .pe_switch_in(sw),
    .pe_valid_out(vout), .pe_input_out(dout), .pe_psum_out(pout), .pe_accept_w_out(aout),
    .pe_weight_out(wout), .pe_switch_out(swout), .pe_ovf_out(ovf), .pe_wdrop_out(wdrop),
    .pe_wcount_out(wcnt)
  );

  pe_mac_param #(.SAT_EN(0), .ROUND_EN(0)) dut_alt (
    .clk(clk), .rst(rst), .pe_enabled(en), .pe_valid_in(vin), .pe_input_in(din),
    .pe_psum_in(pin), .pe_accept_w_in(accw), .pe_weight_in(win), .pe_switch_in(sw),
    .pe_valid_out(a_vout), .pe_input_out(a_dout), .pe_psum_out(a_pout), .pe_accept_w_out(a_aout),
    .pe_weight_out(a_wout), .pe_switch_out(a_swout), .pe_ovf_out(a_ovf), .pe_wdrop_out(a_wdrop),
    .pe_wcount_out(a_wcnt)
  );

  task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] p,
                       input logic a, input logic [15:0] w, input logic s);
    vin = v; din = d; pin = p; accw = a; win = w; sw = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    en = 1'b1;
    rst = 1'b0;
    drive(1'b1, 16'h0200, 16'h0100, 1'b1, 16'h0459, 1'b1);
    #3;
    checks++; if (pout !== 16'h0000 || vout !== 1'b0) begin errors++; $display("FAIL reset_async pout=%h vout=%b exp 0000/0", pout, vout); end
    tick; tick;
    checks++; if ({vout, aout, swout, ovf, wdrop, wcnt} !== 7'b0 || dout !== 16'h0 || wout !== 16'h0) begin
      errors++; $display("FAIL reset_hold flags=%b dout=%h wout=%h exp all zero", {vout, aout, swout, ovf, wdrop, wcnt}, dout, wout); end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    tick;
    checks++; if ({vout, aout, swout, ovf, wdrop, wcnt} !== 7'b0 || pout !== 16'h0) begin
      errors++; $display("FAIL reset_release flags=%b pout=%h exp all zero", {vout, aout, swout, ovf, wdrop, wcnt}, pout); end
  endtask

  task automatic test_load_switch;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0459, 1'b0); tick;
    checks++; if (wout !== 16'h0459 || aout !== 1'b1 || wcnt !== 2'd1) begin
      errors++; $display("FAIL load wout=%h aout=%b wcnt=%0d exp 0459/1/1", wout, aout, wcnt); end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    checks++; if (swout !== 1'b1 || wcnt !== 2'd0 || aout !== 1'b0 || wout !== 16'h0) begin
      errors++; $display("FAIL switch swout=%b wcnt=%0d aout=%b wout=%h exp 1/0/0/0000", swout, wcnt, aout, wout); end
    drive(1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h08B2 || vout !== 1'b1 || dout !== 16'h0200 || ovf !== 1'b0) begin
      errors++; $display("FAIL mac_basic pout=%h vout=%b dout=%h ovf=%b exp 08B2/1/0200/0", pout, vout, dout, ovf); end
    drive(1'b0, 16'h0200, 16'h1234, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0000 || vout !== 1'b0 || dout !== 16'h0000 || swout !== 1'b0) begin
      errors++; $display("FAIL idle_clear pout=%h vout=%b dout=%h swout=%b exp 0", pout, vout, dout, swout); end
  endtask

  task automatic test_switch_timing;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0A9A, 1'b0); tick;
    drive(1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0, 1'b1); tick;
    checks++; if (pout !== 16'h08B2) begin errors++; $display("FAIL switch_same_cycle pout=%h exp 08B2", pout); end
    drive(1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h1534) begin errors++; $display("FAIL switch_next_cycle pout=%h exp 1534", pout); end
    drive(1'b1, 16'h0200, 16'h0100, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h1634) begin errors++; $display("FAIL psum_add pout=%h exp 1634", pout); end
  endtask

  task automatic test_saturation;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0200, 1'b0); tick;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h7F00, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h7FFF || ovf !== 1'b1) begin errors++; $display("FAIL sat_prod pout=%h ovf=%b exp 7FFF/1", pout, ovf); end
    checks++; if (a_pout !== 16'hFE00 || a_ovf !== 1'b1) begin errors++; $display("FAIL wrap_prod pout=%h ovf=%b exp FE00/1", a_pout, a_ovf); end
    drive(1'b1, 16'h3000, 16'h3000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h7FFF || ovf !== 1'b1) begin errors++; $display("FAIL sat_sum pout=%h ovf=%b exp 7FFF/1", pout, ovf); end
    checks++; if (a_pout !== 16'h9000 || a_ovf !== 1'b1) begin errors++; $display("FAIL wrap_sum pout=%h ovf=%b exp 9000/1", a_pout, a_ovf); end
    drive(1'b1, 16'hC000, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h8000 || ovf !== 1'b0 || a_pout !== 16'h8000 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL min_edge pout=%h ovf=%b alt=%h/%b exp 8000/0 both", pout, ovf, a_pout, a_ovf); end
  endtask

  task automatic test_rounding;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0080, 1'b0); tick;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0001 || a_pout !== 16'h0000) begin errors++; $display("FAIL round_pos rnd=%h trunc=%h exp 0001/0000", pout, a_pout); end
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0000 || a_pout !== 16'hFFFF) begin errors++; $display("FAIL round_neg rnd=%h trunc=%h exp 0000/FFFF", pout, a_pout); end
  endtask

  task automatic test_fifo_overflow;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 1'b0); tick;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0200, 1'b0); tick;
    checks++; if (wcnt !== 2'd2 || wdrop !== 1'b0) begin errors++; $display("FAIL fifo_full wcnt=%0d wdrop=%b exp 2/0", wcnt, wdrop); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0300, 1'b0); tick;
    checks++; if (wcnt !== 2'd2 || wdrop !== 1'b1 || wout !== 16'h0300) begin
      errors++; $display("FAIL fifo_drop wcnt=%0d wdrop=%b wout=%h exp 2/1/0300", wcnt, wdrop, wout); end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0100 || wcnt !== 2'd1) begin errors++; $display("FAIL fifo_first pout=%h wcnt=%0d exp 0100/1", pout, wcnt); end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0200 || wcnt !== 2'd0) begin errors++; $display("FAIL fifo_second pout=%h wcnt=%0d exp 0200/0", pout, wcnt); end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0200) begin errors++; $display("FAIL switch_empty pout=%h exp 0200", pout); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0400, 1'b0); tick;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0500, 1'b0); tick;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0600, 1'b1); tick;
    checks++; if (wcnt !== 2'd2) begin errors++; $display("FAIL push_pop_full wcnt=%0d exp 2", wcnt); end
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0400) begin errors++; $display("FAIL push_pop_head pout=%h exp 0400", pout); end
  endtask

  task automatic test_enable;
    en = 1'b0;
    drive(1'b1, 16'h0300, 16'h0011, 1'b1, 16'h0700, 1'b1); tick;
    checks++; if (vout !== 1'b0 || aout !== 1'b0 || swout !== 1'b0 || pout !== 16'h0400 || dout !== 16'h0100 || wcnt !== 2'd2) begin
      errors++; $display("FAIL disabled v=%b a=%b s=%b pout=%h dout=%h wcnt=%0d exp 0/0/0/0400/0100/2", vout, aout, swout, pout, dout, wcnt); end
    en = 1'b1;
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0400 || vout !== 1'b1) begin errors++; $display("FAIL reenable pout=%h vout=%b exp 0400/1", pout, vout); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 16'h0100, 16'h0123, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0523) begin errors++; $display("FAIL burst pout=%h exp 0523", pout); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pout !== 16'h0 || dout !== 16'h0 || vout !== 1'b0 || wcnt !== 2'd0 || wdrop !== 1'b0) begin
      errors++; $display("FAIL reset_mid pout=%h dout=%h vout=%b wcnt=%0d wdrop=%b exp all zero", pout, dout, vout, wcnt, wdrop); end
    rst = 1'b1;
    tick;
    checks++; if (pout !== 16'h0123 || vout !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL post_reset_mac pout=%h vout=%b ovf=%b exp 0123/1/0", pout, vout, ovf); end
    drive(1'b1, 16'h0100, 16'h0042, 1'b0, 16'h0, 1'b1); tick;
    drive(1'b1, 16'h0100, 16'h0042, 1'b0, 16'h0, 1'b0); tick;
    checks++; if (pout !== 16'h0042 || wcnt !== 2'd0) begin errors++; $display("FAIL post_reset_switch pout=%h wcnt=%0d exp 0042/0", pout, wcnt); end
  endtask

  initial begin
    test_reset;
    test_load_switch;
    test_switch_timing;
    test_saturation;
    test_rounding;
    test_fifo_overflow;
    test_enable;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
